// File: rtl/miss_victim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : miss_victim_ctrl
//  Purpose  : Per-core L1 miss handler. Picks a victim way (lowest invalid
//             way, else tree-LRU victim), writes back dirty (M/O) victims,
//             requests the fill, installs the line and updates the LRU.
//  Revision : 1.0  initial release
// ============================================================================
module miss_victim_ctrl #(
   parameter int SETS   = 128,
   parameter int TAG_W  = 20,
   parameter int SET_W  = $clog2(SETS),
   parameter int ADDR_W = TAG_W + SET_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_valid,
   output logic              miss_ready,
   input  logic [SET_W-1:0]  miss_set,
   input  logic [TAG_W-1:0]  miss_tag,
   input  logic              miss_is_write,
   output logic [SET_W-1:0]  lru_set,
   input  logic [1:0]        lru_victim_way,
   output logic              lru_upd,
   output logic [1:0]        lru_way,
   input  logic [3:0]        way_inv,
   output logic              meta_rd_en,
   output logic [1:0]        meta_rd_way,
   input  logic [TAG_W-1:0]  meta_rd_tag,
   input  logic [2:0]        meta_rd_state,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              fill_req_valid,
   input  logic              fill_req_ready,
   output logic [ADDR_W-1:0] fill_req_addr,
   output logic              fill_req_excl,
   input  logic              fill_resp_valid,
   input  logic [2:0]        fill_resp_state,
   output logic              meta_wr_en,
   output logic [1:0]        meta_wr_way,
   output logic [TAG_W-1:0]  meta_wr_tag,
   output logic [2:0]        meta_wr_state,
   output logic              miss_done,
   output logic [1:0]        miss_done_way
);

   // MOESI encoding
   localparam logic [2:0] C_ST_I = 3'd0;
   localparam logic [2:0] C_ST_O = 3'd3;
   localparam logic [2:0] C_ST_M = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEL   = 3'd1,
      META  = 3'd2,
      WB    = 3'd3,
      FREQ  = 3'd4,
      FWAIT = 3'd5,
      INST  = 3'd6
   } state_t;

   state_t            r_state;
   logic [SET_W-1:0]  r_set;
   logic [TAG_W-1:0]  r_tag;
   logic              r_write;
   logic [1:0]        r_victim;
   logic [TAG_W-1:0]  r_vtag;
   logic [1:0]        w_victim;

   // Victim choice: an invalid way always beats evicting a live line
   always_comb begin
      w_victim = lru_victim_way;
      if (way_inv[0])      w_victim = 2'd0;
      else if (way_inv[1]) w_victim = 2'd1;
      else if (way_inv[2]) w_victim = 2'd2;
      else if (way_inv[3]) w_victim = 2'd3;
   end

   // The LRU block is queried with the live request while idle so SEL sees a settled answer
   assign lru_set       = (r_state == IDLE) ? miss_set : r_set;
   assign meta_rd_en    = (r_state == SEL);
   assign meta_rd_way   = (r_state == SEL) ? w_victim : r_victim;
   assign wb_addr       = {r_vtag, r_set};
   assign fill_req_addr = {r_tag, r_set};
   assign fill_req_excl = r_write;
   assign lru_way       = r_victim;
   assign meta_wr_way   = r_victim;
   assign miss_done_way = r_victim;
   assign meta_wr_tag   = r_tag;

   // Miss sequencing FSM with registered handshake and strobe outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_set          <= '0;
         r_tag          <= '0;
         r_write        <= 1'b0;
         r_victim       <= 2'd0;
         r_vtag         <= '0;
         miss_ready     <= 1'b1;
         wb_valid       <= 1'b0;
         fill_req_valid <= 1'b0;
         meta_wr_en     <= 1'b0;
         lru_upd        <= 1'b0;
         miss_done      <= 1'b0;
         meta_wr_state  <= C_ST_I;
      end else begin
         meta_wr_en <= 1'b0;
         lru_upd    <= 1'b0;
         miss_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (miss_valid) begin
                  r_set      <= miss_set;
                  r_tag      <= miss_tag;
                  r_write    <= miss_is_write;
                  miss_ready <= 1'b0;
                  r_state    <= SEL;
               end
            end
            SEL: begin
               r_victim <= w_victim;
               r_state  <= META;
            end
            META: begin
               r_vtag <= meta_rd_tag;
               if ((meta_rd_state == C_ST_M) || (meta_rd_state == C_ST_O)) begin
                  wb_valid <= 1'b1;
                  r_state  <= WB;
               end else begin
                  fill_req_valid <= 1'b1;
                  r_state        <= FREQ;
               end
            end
            WB: begin
               if (wb_ready) begin
                  wb_valid       <= 1'b0;
                  fill_req_valid <= 1'b1;
                  r_state        <= FREQ;
               end
            end
            FREQ: begin
               if (fill_req_ready) begin
                  fill_req_valid <= 1'b0;
                  r_state        <= FWAIT;
               end
            end
            FWAIT: begin
               if (fill_resp_valid) begin
                  meta_wr_state <= r_write ? C_ST_M : fill_resp_state;
                  meta_wr_en    <= 1'b1;
                  lru_upd       <= 1'b1;
                  miss_done     <= 1'b1;
                  r_state       <= INST;
               end
            end
            INST: begin
               miss_ready <= 1'b1;
               r_state    <= IDLE;
            end
            default: begin
               wb_valid       <= 1'b0;
               fill_req_valid <= 1'b0;
               miss_ready     <= 1'b1;
               r_state        <= IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Victim metadata must carry a legal MOESI code
   a_legal_meta_state: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == META) |-> (meta_rd_state <= C_ST_M));
   // The fabric may only complete a fill that is being waited for
   a_resp_only_in_fwait: assert property (@(posedge clk) disable iff (!rst_n)
      fill_resp_valid |-> (r_state == FWAIT));
`endif

endmodule
`default_nettype wire
